// File: rtl/cp0_exception_ctrl.sv
// CP0 STATUS/CAUSE/EPC registers and the exception entry/return sequencer
// for the single-cycle MIPS core. Redirect and kill are registered, state-driven.
module cp0_exception_ctrl #(
  parameter int          NIRQ    = 3,
  parameter logic [31:0] VEC_INT = 32'h0000_4180,
  parameter logic [31:0] VEC_SYS = 32'h0000_4200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic            sys,
  input  logic            exce_ret,
  input  logic            mfc0,
  input  logic            mtc0,
  input  logic [4:0]      cp0_addr,
  input  logic [31:0]     wdata,
  input  logic [31:0]     pc_next,
  input  logic [NIRQ-1:0] irq,
  output logic [31:0]     rdata,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            kill,
  output logic            exl,
  output logic [31:0]     epc
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_ENTER   = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;
  localparam logic [1:0] S_RETURN  = 2'd3;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  logic [1:0]      r_state;
  logic            r_ie;
  logic            r_exl;
  logic [2:0]      r_im;
  logic [2:0]      r_ip;
  logic [4:0]      r_exc;
  logic [31:0]     r_epc;
  logic [NIRQ-1:0] r_irq_q;
  logic            r_redirect;
  logic [31:0]     r_redirect_pc;
  logic            r_kill;

  logic            w_eff;
  logic            w_wr_status;
  logic            w_wr_cause;
  logic            w_wr_epc;
  logic [2:0]      w_rise;
  logic [2:0]      w_pend;
  logic [2:0]      w_clr;
  logic            w_sys_trig;
  logic            w_int_trig;
  logic            w_trig;
  logic            w_eret;
  logic [1:0]      w_state_nxt;
  logic            w_ie_nxt;
  logic            w_exl_nxt;
  logic [2:0]      w_im_nxt;
  logic [2:0]      w_ip_nxt;
  logic [4:0]      w_exc_nxt;
  logic [31:0]     w_epc_nxt;
  logic [31:0]     w_rdata;

  // Strobes of an instruction being squashed by a redirect must not act.
  assign w_eff       = instr_valid & ~r_kill;
  assign w_wr_status = w_eff & mtc0 & (cp0_addr == A_STATUS);
  assign w_wr_cause  = w_eff & mtc0 & (cp0_addr == A_CAUSE);
  assign w_wr_epc    = w_eff & mtc0 & (cp0_addr == A_EPC);

  assign w_rise = 3'(irq & ~r_irq_q);
  assign w_pend = r_ip & r_im;

  assign w_sys_trig = (r_state == S_RUN) & w_eff & sys & ~r_exl;
  assign w_int_trig = (r_state == S_RUN) & w_eff & r_ie & ~r_exl & (|w_pend) & ~w_sys_trig;
  assign w_trig     = w_sys_trig | w_int_trig;
  assign w_eret     = (r_state == S_HANDLER) & w_eff & exce_ret;

  // Only the highest-priority pending line is acknowledged on entry.
  always_comb begin
    w_clr = 3'b000;
    if (w_pend[2])      w_clr = 3'b100;
    else if (w_pend[1]) w_clr = 3'b010;
    else if (w_pend[0]) w_clr = 3'b001;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (w_trig) w_state_nxt = S_ENTER;
      S_ENTER:   w_state_nxt = S_HANDLER;
      S_HANDLER: if (w_eret) w_state_nxt = S_RETURN;
      S_RETURN:  w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  // Software writes first, hardware entry/return updates override them.
  always_comb begin
    w_ie_nxt  = r_ie;
    w_exl_nxt = r_exl;
    w_im_nxt  = r_im;
    w_ip_nxt  = r_ip;
    w_exc_nxt = r_exc;
    w_epc_nxt = r_epc;
    if (w_wr_status) begin
      w_ie_nxt  = wdata[0];
      w_exl_nxt = wdata[1];
      w_im_nxt  = wdata[10:8];
    end
    if (w_wr_cause) w_ip_nxt  = wdata[10:8];
    if (w_wr_epc)   w_epc_nxt = wdata;
    if (w_trig) begin
      w_exl_nxt = 1'b1;
      w_epc_nxt = pc_next;
      w_exc_nxt = w_sys_trig ? EXC_SYS : EXC_INT;
    end
    if (w_int_trig) w_ip_nxt = w_ip_nxt & ~w_clr;
    if (w_eret)     w_exl_nxt = 1'b0;
    w_ip_nxt = w_ip_nxt | w_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_ie          <= 1'b0;
      r_exl         <= 1'b0;
      r_im          <= 3'b000;
      r_ip          <= 3'b000;
      r_exc         <= 5'd0;
      r_epc         <= 32'd0;
      r_irq_q       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_kill        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ie       <= w_ie_nxt;
      r_exl      <= w_exl_nxt;
      r_im       <= w_im_nxt;
      r_ip       <= w_ip_nxt;
      r_exc      <= w_exc_nxt;
      r_epc      <= w_epc_nxt;
      r_irq_q    <= irq;
      r_redirect <= (w_state_nxt == S_ENTER) | (w_state_nxt == S_RETURN);
      r_kill     <= (w_state_nxt == S_ENTER) | (w_state_nxt == S_RETURN);
      if (w_state_nxt == S_ENTER)
        r_redirect_pc <= w_sys_trig ? VEC_SYS : VEC_INT;
      else if (w_state_nxt == S_RETURN)
        r_redirect_pc <= w_epc_nxt;
      else
        r_redirect_pc <= 32'd0;
    end
  end

  // Read port is qualified by the decoded MFC0.
  always_comb begin
    w_rdata = 32'd0;
    if (mfc0) begin
      case (cp0_addr)
        A_STATUS: w_rdata = {21'd0, r_im, 6'd0, r_exl, r_ie};
        A_CAUSE:  w_rdata = {21'd0, r_ip, 1'b0, r_exc, 2'b00};
        A_EPC:    w_rdata = r_epc;
        default:  w_rdata = 32'd0;
      endcase
    end
  end

  assign rdata       = w_rdata;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign kill        = r_kill;
  assign exl         = r_exl;
  assign epc         = r_epc;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench for cp0_exception_ctrl: interrupt/syscall entry, return,
// priority, masking, handler isolation and async reset during ENTER.
module tb_cp0_exception_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, sys, exce_ret, mfc0, mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata, pc_next;
  logic [2:0]  irq;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        kill, exl;
  logic [31:0] epc;

  int checks   = 0;
  int failures = 0;

  cp0_exception_ctrl #(.NIRQ(3), .VEC_INT(32'h0000_4180), .VEC_SYS(32'h0000_4200)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .sys(sys), .exce_ret(exce_ret),
    .mfc0(mfc0), .mtc0(mtc0), .cp0_addr(cp0_addr), .wdata(wdata), .pc_next(pc_next),
    .irq(irq), .rdata(rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .kill(kill), .exl(exl), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    mfc0 = 1'b1; mtc0 = 1'b0; cp0_addr = a;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 1'b0;
  endtask

  task automatic idle();
    instr_valid = 0; sys = 0; exce_ret = 0; mfc0 = 0; mtc0 = 0;
    cp0_addr = 0; wdata = 0; pc_next = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    instr_valid = 1; mtc0 = 1; cp0_addr = a; wdata = d;
    tick();
  endtask

  task automatic do_eret();
    instr_valid = 1; exce_ret = 1;
    tick();
  endtask

  initial begin
    rst = 1; irq = 3'b000;
    idle();
    repeat (2) tick();
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_kill", {31'd0, kill}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rd(5'd12, "rst_status", 32'd0);
    rst = 0;
    tick();

    // Interrupt entry on irq[0]
    do_mtc0(5'd12, 32'h0000_0101);
    rd(5'd12, "t1_status", 32'h0000_0101);
    irq = 3'b001;
    tick();
    rd(5'd13, "t1_cause_ip", 32'h0000_0100);
    chk("t1_no_redirect", {31'd0, redirect}, 32'd0);
    instr_valid = 1; pc_next = 32'h0000_3010;
    tick();
    chk("t1_redirect", {31'd0, redirect}, 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h0000_4180);
    chk("t1_kill", {31'd0, kill}, 32'd1);
    chk("t1_exl", {31'd0, exl}, 32'd1);
    chk("t1_epc", epc, 32'h0000_3010);
    rd(5'd13, "t1_cause", 32'h0000_0000);
    instr_valid = 1;
    tick();
    chk("t1_handler_redirect", {31'd0, redirect}, 32'd0);
    chk("t1_handler_kill", {31'd0, kill}, 32'd0);
    do_eret();
    chk("t1_ret_redirect", {31'd0, redirect}, 32'd1);
    chk("t1_ret_pc", redirect_pc, 32'h0000_3010);
    chk("t1_ret_exl", {31'd0, exl}, 32'd0);
    tick();
    chk("t1_run_redirect", {31'd0, redirect}, 32'd0);
    irq = 3'b000;
    tick();

    // Syscall entry, handler isolation, return, ERET in RUN
    instr_valid = 1; sys = 1; pc_next = 32'h0000_3024;
    tick();
    chk("t2_redirect_pc", redirect_pc, 32'h0000_4200);
    chk("t2_epc", epc, 32'h0000_3024);
    rd(5'd13, "t2_cause", 32'h0000_0020);
    tick();
    irq = 3'b001; instr_valid = 1; sys = 1; pc_next = 32'h0000_5000;
    tick();
    chk("t2_hdl_no_redirect", {31'd0, redirect}, 32'd0);
    chk("t2_hdl_epc", epc, 32'h0000_3024);
    chk("t2_hdl_exl", {31'd0, exl}, 32'd1);
    rd(5'd13, "t2_hdl_cause", 32'h0000_0120);
    do_mtc0(5'd13, 32'h0000_0000);
    rd(5'd13, "t2_cause_clr", 32'h0000_0020);
    do_eret();
    chk("t2_ret_redirect", {31'd0, redirect}, 32'd1);
    chk("t2_ret_pc", redirect_pc, 32'h0000_3024);
    chk("t2_ret_kill", {31'd0, kill}, 32'd1);
    chk("t2_ret_exl", {31'd0, exl}, 32'd0);
    tick();
    do_eret();
    chk("t2_run_eret_redirect", {31'd0, redirect}, 32'd0);
    chk("t2_run_eret_exl", {31'd0, exl}, 32'd0);
    irq = 3'b000;
    tick();

    // Syscall beats a same-cycle interrupt, which is taken after ERET
    do_mtc0(5'd12, 32'h0000_0301);
    irq = 3'b010;
    tick();
    rd(5'd13, "t3_cause_ip9", 32'h0000_0220);
    instr_valid = 1; sys = 1; pc_next = 32'h0000_3100;
    tick();
    chk("t3_sys_vec", redirect_pc, 32'h0000_4200);
    rd(5'd13, "t3_ip9_kept", 32'h0000_0220);
    tick();
    do_eret();
    chk("t3_ret_pc", redirect_pc, 32'h0000_3100);
    tick();
    instr_valid = 1; pc_next = 32'h0000_3200;
    tick();
    chk("t3_int_redirect", {31'd0, redirect}, 32'd1);
    chk("t3_int_vec", redirect_pc, 32'h0000_4180);
    chk("t3_int_epc", epc, 32'h0000_3200);
    rd(5'd13, "t3_int_cause", 32'h0000_0000);
    tick();
    do_eret();
    tick();
    irq = 3'b000;
    tick();

    // Masked interrupt stays pending until enabled
    do_mtc0(5'd12, 32'h0000_0001);
    irq = 3'b100;
    tick();
    rd(5'd13, "t4_ip10", 32'h0000_0400);
    instr_valid = 1; pc_next = 32'h0000_3300;
    tick();
    chk("t4_masked_redirect", {31'd0, redirect}, 32'd0);
    instr_valid = 1; mtc0 = 1; cp0_addr = 5'd12; wdata = 32'h0000_0401; pc_next = 32'h0000_3400;
    tick();
    chk("t4_enable_redirect", {31'd0, redirect}, 32'd0);
    instr_valid = 1; pc_next = 32'h0000_3500;
    tick();
    chk("t4_redirect", {31'd0, redirect}, 32'd1);
    chk("t4_vec", redirect_pc, 32'h0000_4180);
    chk("t4_epc", epc, 32'h0000_3500);

    // Async reset in the middle of ENTER
    irq = 3'b000;
    #1 rst = 1;
    #1;
    chk("t5_redirect", {31'd0, redirect}, 32'd0);
    chk("t5_kill", {31'd0, kill}, 32'd0);
    chk("t5_exl", {31'd0, exl}, 32'd0);
    chk("t5_epc", epc, 32'd0);
    rd(5'd12, "t5_status", 32'd0);
    rd(5'd13, "t5_cause", 32'd0);
    tick();
    rst = 0;
    tick();
    chk("t5_no_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("t5_no_redirect2", {31'd0, redirect}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Coprocessor-0 register file plus exception sequencer for the single-cycle MIPS core.
- Consumes the decoder strobes (sys, exce_ret, mfc0, mtc0) and external interrupt lines.
- Holds STATUS, CAUSE and EPC.
- Drives PC redirect and instruction-kill controls to enter the handler and return from it.

Parameters:
- NIRQ, 3, number of external interrupt lines (max 3, mapped to CAUSE/STATUS bits [10:8]).
- VEC_INT, 32'h0000_4180, handler address for interrupts.
- VEC_SYS, 32'h0000_4200, handler address for syscall.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  current instruction retires this cycle
- sys  in  1  decoded SYSCALL
- exce_ret  in  1  decoded ERET
- mfc0  in  1  decoded MFC0 (read is combinational)
- mtc0  in  1  decoded MTC0
- cp0_addr  in  5  rd field, selects the CP0 register
- wdata  in  32  rt value for MTC0
- pc_next  in  32  address the datapath would fetch next
- irq  in  NIRQ  external interrupt levels
- rdata  out  32  CP0 read data
- redirect  out  1  datapath must load redirect_pc as next PC
- redirect_pc  out  32  redirect target
- kill  out  1  squash register/memory writes of the current instruction
- exl  out  1  STATUS.EXL, in-handler flag
- epc  out  32  EPC register

Behaviour:
- Registers:
  - STATUS (addr 12): bit0 IE, bit1 EXL, [10:8] IM; other bits read 0.
  - CAUSE (addr 13): [10:8] IP, [6:2] ExcCode; other bits read 0.
  - EPC (addr 14).
  - rdata = selected register; any other address reads 0.
- Reset (async) values:
  - All registers 0.
  - State RUN; redirect=0, redirect_pc=0, kill=0.
- IRQ capture:
  - irq is registered once (irq_q).
  - A rising edge (irq & ~irq_q) sets IP[i].
  - Set wins over a same-cycle clear of the same bit.
- Effective strobe: eff = instr_valid & ~kill. Decoder strobes are ignored when eff=0.
- MTC0, at the edge when eff & mtc0:
  - Writes the addressed register (STATUS: IE/EXL/IM bits; CAUSE: IP only; EPC: full 32 bits).
  - Entry and return updates below override a same-cycle MTC0 write to the same field.
- FSM states: RUN, ENTER, HANDLER, RETURN.
- RUN:
  - Syscall trigger: eff & sys & ~EXL.
  - Interrupt trigger: eff & IE & ~EXL & |(IP & IM).
  - Syscall wins when both trigger; the interrupt stays pending.
  - On trigger, at the edge:
    - EPC <= pc_next; EXL <= 1.
    - ExcCode <= 8 (syscall) or 0 (interrupt).
    - For an interrupt, clear the highest-numbered IP bit that is set in IP & IM.
    - Latch the vector; go to ENTER.
  - The triggering instruction itself retires normally.
- ENTER (exactly 1 cycle):
  - redirect=1, redirect_pc=VEC_SYS or VEC_INT, kill=1.
  - Next state HANDLER.
- HANDLER:
  - Interrupts are masked (EXL=1); sys is ignored.
  - On eff & exce_ret: EXL <= 0, go to RETURN.
- RETURN (exactly 1 cycle):
  - redirect=1, redirect_pc=EPC, kill=1.
  - Next state RUN.
  - The new EXL=0 takes effect, so a pending interrupt can trigger on the first eff instruction in RUN.
- In RUN, exce_ret is a NOP (no state change). MTC0 clearing EXL in HANDLER does not change the FSM state.
- redirect, redirect_pc and kill are registered outputs, driven from state, with zero combinational path from inputs.
- Reset asserted mid-ENTER, mid-HANDLER or mid-RETURN returns immediately to reset values; no redirect is emitted.

Test Plan:
- Reset, then MTC0 STATUS=0x0000_0101 (IE=1, IM[8]=1), raise irq[0] with pc_next=0x0000_3010 -> next eff cycle triggers. Required:
  - EPC=0x3010, CAUSE.ExcCode=0, IP[8]=0.
  - ENTER cycle: redirect=1, redirect_pc=0x4180, kill=1.
  - exl=1.
- sys with pc_next=0x0000_3024 and EXL=0 -> EPC=0x3024, ExcCode=8, redirect_pc=0x4200 in ENTER. Later ERET -> RETURN cycle redirect_pc=0x3024, kill=1, exl=0.
- sys and enabled irq[1] in the same cycle -> syscall taken and IP[9] stays 1. After ERET, the first eff instruction in RUN takes the interrupt (ExcCode=0).
- irq[2] edge while IM=0 or IE=0 -> IP[10]=1, no redirect. Enabling via MTC0 then triggers on the next eff instruction.
- Inside HANDLER: irq edge and sys are ignored (no redirect, EPC unchanged). ERET in RUN causes no redirect.
- Assert rst during ENTER -> redirect, kill, exl, EPC, CAUSE and STATUS all 0 immediately. No redirect follows.
